// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Brief    : Shared types and constants for the ALU issue/writeback slice
//             (datapath width, opcodes, FSM states, instruction word).
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int DATA_W    = 4;
  localparam int NREGS_DEF = 4;
  localparam int IDX_W     = $clog2(NREGS_DEF);

  // ALU opcodes; OP_LDI never reaches the ALU
  localparam logic [3:0] OP_INC  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUBC = 4'b0010;
  localparam logic [3:0] OP_DEC  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_CLR  = 4'b1000;
  localparam logic [3:0] OP_LDI  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [IDX_W-1:0]  ra;
    logic [IDX_W-1:0]  rb;
    logic [IDX_W-1:0]  rd;
    logic              cin;
    logic [DATA_W-1:0] imm;
  } instr_t;

  function automatic logic is_ldi(input logic [3:0] op);
    return op == OP_LDI;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : alu_regfile
//  Brief    : NREGS x DATA_W register file, one synchronous write port and
//             three combinational read ports (operand A, operand B, debug).
//  Revision : 1.0 - initial release
// ============================================================================
module alu_regfile #(
  parameter int NREGS  = 4,
  parameter int DATA_W = 4,
  localparam int IW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IW-1:0]     ra_idx,
  output logic [DATA_W-1:0] ra_data,
  input  logic [IW-1:0]     rb_idx,
  output logic [DATA_W-1:0] rb_data,
  input  logic [IW-1:0]     dbg_idx,
  output logic [DATA_W-1:0] dbg_data
);
  import alu_pkg::*;

  logic [DATA_W-1:0] r_mem [NREGS];

  // Storage: cleared on reset, one write per enabled cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // NREGS is a power of two, so every index is in range
  assign ra_data  = r_mem[ra_idx];
  assign rb_data  = r_mem[rb_idx];
  assign dbg_data = r_mem[dbg_idx];

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl
//  Brief    : Issue/writeback controller for a 4-bit registered ALU. Accepts
//             one instruction at a time, drives the ALU for one cycle,
//             captures its result a cycle later and writes it back.
//             Optional macro ALU_ZFLAG_EN adds a sticky zero flag output zf.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int NREGS  = alu_pkg::NREGS_DEF,
  parameter int DATA_W = alu_pkg::DATA_W,
  localparam int IW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [IW-1:0]     instr_ra,
  input  logic [IW-1:0]     instr_rb,
  input  logic [IW-1:0]     instr_rd,
  input  logic              instr_cin,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_cin,
  output logic [3:0]        alu_op,
  output logic              alu_en,
  input  logic [DATA_W-1:0] alu_y,
  output logic              wb_valid,
  output logic [IW-1:0]     wb_idx,
  output logic [DATA_W-1:0] wb_data,
`ifdef ALU_ZFLAG_EN
  output logic              zf,
`endif
  input  logic [IW-1:0]     dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);
  import alu_pkg::*;

  state_t            r_state;
  state_t            w_next_state;
  instr_t            r_instr;
  logic              w_accept;
  logic              w_wb;
  logic [DATA_W-1:0] w_rf_a;
  logic [DATA_W-1:0] w_rf_b;
  logic [DATA_W-1:0] w_result;

  // Next-state and handshake decode
  always_comb begin
    w_next_state = r_state;
    instr_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          w_next_state = is_ldi(instr_op) ? ST_WB : ST_ISSUE;
        end
      end
      ST_ISSUE: w_next_state = ST_WB;
      ST_WB:    w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  assign w_accept = instr_valid & instr_ready;
  assign w_wb     = (r_state == ST_WB);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Instruction register, loaded on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= '0;
    end else if (w_accept) begin
      r_instr <= '{op: instr_op, ra: instr_ra, rb: instr_rb, rd: instr_rd,
                   cin: instr_cin, imm: instr_imm};
    end
  end

  // ALU drive: operands are sampled on the accept edge so they are stable
  // registers for the whole ISSUE cycle; they hold afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_en  <= 1'b0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      alu_cin <= 1'b0;
    end else begin
      alu_en <= w_accept && !is_ldi(instr_op);
      if (w_accept && !is_ldi(instr_op)) begin
        alu_a   <= w_rf_a;
        alu_b   <= w_rf_b;
        alu_op  <= instr_op;
        alu_cin <= instr_cin;
      end
    end
  end

  // ALU y is only valid in the cycle after en, which is the WB cycle
  assign w_result = is_ldi(r_instr.op) ? r_instr.imm : alu_y;
  assign wb_valid = w_wb;
  assign wb_idx   = w_wb ? r_instr.rd : '0;
  assign wb_data  = w_wb ? w_result : '0;

  alu_regfile #(
    .NREGS  (NREGS),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (w_wb),
    .waddr    (r_instr.rd),
    .wdata    (w_result),
    .ra_idx   (instr_ra),
    .ra_data  (w_rf_a),
    .rb_idx   (instr_rb),
    .rb_data  (w_rf_b),
    .dbg_idx  (dbg_sel),
    .dbg_data (dbg_data)
  );

`ifdef ALU_ZFLAG_EN
  // Zero flag follows the written-back value, held between writebacks
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       zf <= 1'b0;
    else if (w_wb) zf <= (w_result == '0);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_ctrl
//  Brief    : Self-checking bench for alu_issue_ctrl with a behavioural
//             registered ALU; writeback and ALU-issue scoreboards.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [3:0] instr_op = '0;
  logic [1:0] instr_ra = '0, instr_rb = '0, instr_rd = '0;
  logic       instr_cin = 1'b0;
  logic [3:0] instr_imm = '0;
  logic [3:0] alu_a, alu_b, alu_op;
  logic       alu_cin, alu_en;
  logic [3:0] alu_y = '0;
  logic       wb_valid;
  logic [1:0] wb_idx;
  logic [3:0] wb_data;
  logic [1:0] dbg_sel = '0;
  logic [3:0] dbg_data;
`ifdef ALU_ZFLAG_EN
  logic       zf;
`endif

  int checks = 0;
  int errors = 0;
  logic [5:0]  wb_q  [$];
  logic [12:0] alu_q [$];
  logic        prev_alu_en = 1'b0;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_ra(instr_ra), .instr_rb(instr_rb),
    .instr_rd(instr_rd), .instr_cin(instr_cin), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_en(alu_en), .alu_y(alu_y),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
`ifdef ALU_ZFLAG_EN
    .zf(zf),
`endif
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit registered ALU
  function automatic logic [3:0] alu_f(input logic [3:0] op, a, b, input logic c);
    case (op)
      4'b0000: return a + 4'd1;
      4'b0001: return a + b + {3'b0, c};
      4'b0010: return a + ~b + {3'b0, c};
      4'b0011: return a - 4'd1;
      4'b0100: return a & b;
      4'b0101: return a | b;
      4'b0110: return a ^ b;
      4'b0111: return ~a;
      default: return 4'd0;
    endcase
  endfunction

  always @(posedge clk) if (alu_en) alu_y <= alu_f(alu_op, alu_a, alu_b, alu_cin);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor step, run at every falling edge
  task automatic monitor_step();
    logic [5:0]  we;
    logic [12:0] ae;
    if (wb_valid) begin
      if (wb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_unexpected: got idx=%0d data=%0d expected no writeback at %0t",
                 wb_idx, wb_data, $time);
      end else begin
        we = wb_q.pop_front();
        chk("wb_idx", wb_idx, we[5:4]);
        chk("wb_data", wb_data, we[3:0]);
      end
    end
    if (alu_en) begin
      if (prev_alu_en) begin
        checks++; errors++;
        $display("FAIL alu_en_width: got 2+ cycles expected 1 at %0t", $time);
      end
      if (alu_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL alu_unexpected: got alu_en=1 expected 0 at %0t", $time);
      end else begin
        ae = alu_q.pop_front();
        chk("alu_a", alu_a, ae[12:9]);
        chk("alu_b", alu_b, ae[8:5]);
        chk("alu_op", alu_op, ae[4:1]);
        chk("alu_cin", alu_cin, ae[0]);
      end
    end
    prev_alu_en = alu_en;
  endtask

  task automatic set_fields(input logic [3:0] op, input logic [1:0] ra, rb, rd,
                            input logic cin, input logic [3:0] imm);
    instr_op = op; instr_ra = ra; instr_rb = rb; instr_rd = rd;
    instr_cin = cin; instr_imm = imm;
  endtask

  task automatic push_exp(input logic [3:0] op, input logic [1:0] rd, input logic cin,
                          input logic [3:0] exp_d, ea, eb);
    wb_q.push_back({rd, exp_d});
    if (op != 4'hF) alu_q.push_back({ea, eb, op, cin});
  endtask

  // Offer one instruction and wait (bounded) for it to be accepted
  task automatic send(input logic [3:0] op, input logic [1:0] ra, rb, rd,
                      input logic cin, input logic [3:0] imm,
                      input logic [3:0] exp_d, ea, eb, input bit push);
    bit acc = 0;
    set_fields(op, ra, rb, rd, cin, imm);
    instr_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (instr_ready) begin
        if (push) push_exp(op, rd, cin, exp_d, ea, eb);
        @(posedge clk); #1;
        acc = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no accept expected accept op=%0d", op);
    end
  endtask

  task automatic go_idle();
    bit seen = 0;
    instr_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (instr_ready) seen = 1;
    end
    chk("idle_reached", seen, 1);
    chk("wb_q_drained", wb_q.size(), 0);
  endtask

  task automatic chk_dbg(input logic [1:0] idx, input logic [3:0] exp);
    dbg_sel = idx; #1;
    chk("dbg_data", dbg_data, exp);
  endtask

  logic [3:0] b2b_op [3] = '{4'h1, 4'h1, 4'h1};
  logic [1:0] b2b_ra [3] = '{2'd0, 2'd2, 2'd1};
  logic [1:0] b2b_rb [3] = '{2'd1, 2'd2, 2'd1};
  logic [1:0] b2b_rd [3] = '{2'd2, 2'd3, 2'd1};
  logic       b2b_ci [3] = '{1'b0, 1'b0, 1'b1};
  logic [3:0] b2b_ea [3] = '{4'd5, 4'd8, 4'd3};
  logic [3:0] b2b_eb [3] = '{4'd3, 4'd8, 4'd3};
  logic [3:0] b2b_y  [3] = '{4'd8, 4'd0, 4'd7};
  logic       b2b_rdy[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_alu_en", alu_en, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_cin", alu_cin, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_idx", wb_idx, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_ready", instr_ready, 1);
    for (int r = 0; r < 4; r++) chk_dbg(r[1:0], 4'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // LDI r0=5, r1=3
    send(4'hF, 0, 0, 0, 0, 4'd5, 4'd5, 0, 0, 1); go_idle(); chk_dbg(0, 4'd5);
    send(4'hF, 0, 0, 1, 0, 4'd3, 4'd3, 0, 0, 1); go_idle(); chk_dbg(1, 4'd3);

    // ADD r2 = r0 + r1 + 1 with cycle-level timing
    send(4'h1, 0, 1, 2, 1, 4'd0, 4'd9, 4'd5, 4'd3, 1);
    chk("add_c1_alu_en", alu_en, 1);
    chk("add_c1_wb_valid", wb_valid, 0);
    @(posedge clk); #1;
    chk("add_c2_alu_en", alu_en, 0);
    chk("add_c2_wb_valid", wb_valid, 1);
    chk("add_c2_wb_data", wb_data, 9);
    @(posedge clk); #1;
    chk("add_c3_ready", instr_ready, 1);
    chk("add_c3_wb_valid", wb_valid, 0);
    go_idle(); chk_dbg(2, 4'd9);

    // SUBC, AND, unsupported opcode
    send(4'h2, 0, 1, 3, 1, 4'd0, 4'd2, 4'd5, 4'd3, 1); go_idle(); chk_dbg(3, 4'd2);
    send(4'h4, 0, 1, 3, 0, 4'd0, 4'd1, 4'd5, 4'd3, 1); go_idle(); chk_dbg(3, 4'd1);
    send(4'hA, 0, 1, 3, 0, 4'd0, 4'd0, 4'd5, 4'd3, 1); go_idle(); chk_dbg(3, 4'd0);

    // Back-to-back ADDs with valid held high (includes full aliasing)
    begin
      int k = 0;
      set_fields(b2b_op[0], b2b_ra[0], b2b_rb[0], b2b_rd[0], b2b_ci[0], 4'd0);
      instr_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
        if (i > 0) @(negedge clk);
        chk("b2b_ready", instr_ready, b2b_rdy[i]);
        if (instr_ready && k < 3) begin
          push_exp(b2b_op[k], b2b_rd[k], b2b_ci[k], b2b_y[k], b2b_ea[k], b2b_eb[k]);
          @(posedge clk); #1;
          k++;
          if (k < 3) set_fields(b2b_op[k], b2b_ra[k], b2b_rb[k], b2b_rd[k], b2b_ci[k], 4'd0);
        end
      end
      chk("b2b_accepts", k, 2);
      send(b2b_op[2], b2b_ra[2], b2b_rb[2], b2b_rd[2], b2b_ci[2], 4'd0,
           b2b_y[2], b2b_ea[2], b2b_eb[2], 1);
      go_idle();
      chk_dbg(1, 4'd7); chk_dbg(2, 4'd8); chk_dbg(3, 4'd0);
    end

    // Reset during ISSUE aborts the instruction
    send(4'hF, 0, 0, 2, 0, 4'd9, 4'd9, 0, 0, 1); go_idle(); chk_dbg(2, 4'd9);
    send(4'h1, 0, 0, 2, 0, 4'd0, 4'd0, 0, 0, 0);
    chk("abort_pre_alu_en", alu_en, 1);
    instr_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("abort_alu_en", alu_en, 0);
    chk("abort_wb_valid", wb_valid, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", instr_ready, 1);
    chk("abort_wb_after", wb_valid, 0);
    for (int r = 0; r < 4; r++) chk_dbg(r[1:0], 4'd0);

`ifdef ALU_ZFLAG_EN
    chk("zf_reset", zf, 0);
    send(4'h6, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 1); go_idle();
    chk("zf_xor", zf, 1);
    repeat (3) @(negedge clk);
    chk("zf_hold", zf, 1);
    send(4'hF, 0, 0, 0, 0, 4'd7, 4'd7, 0, 0, 1); go_idle();
    chk("zf_ldi", zf, 0);
`endif

    repeat (2) @(negedge clk);
    chk("final_wb_q", wb_q.size(), 0);
    chk("final_alu_q", alu_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/writeback controller directly upstream of the 4-bit registered ALU (`clk`, `en`, `a`, `b`, `c_in`, `op_code`, `y` registered on posedge when `en`).
- Accepts instruction words over a valid/ready handshake and reads operands from a small local register file.
- Drives the ALU for exactly one cycle per instruction, then captures `y` one cycle later and writes it back to the destination register.
- One instruction in flight at a time; no hazards possible.

Parameters:
- NREGS, 4: register-file depth; power of 2; index width IW = clog2(NREGS).
- DATA_W, 4: datapath width; must equal ALU width.

Ports:
- clk  in  1  rising-edge clock, shared with ALU
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept
- instr_op  in  4  ALU op_code; 4'b1111 = LDI (internal, no ALU use)
- instr_ra  in  IW  source A register index
- instr_rb  in  IW  source B register index
- instr_rd  in  IW  destination register index
- instr_cin  in  1  carry-in passed to ALU
- instr_imm  in  DATA_W  immediate for LDI
- alu_a  out  DATA_W  to ALU a
- alu_b  out  DATA_W  to ALU b
- alu_cin  out  1  to ALU c_in
- alu_op  out  4  to ALU op_code
- alu_en  out  1  to ALU en
- alu_y  in  DATA_W  from ALU y
- wb_valid  out  1  one-cycle writeback pulse
- wb_idx  out  IW  register written
- wb_data  out  DATA_W  value written
- dbg_sel  in  IW  debug read index
- dbg_data  out  DATA_W  combinational rf[dbg_sel]

Behaviour:
- Reset (async, immediate on rst rise):
  - State = IDLE; all rf entries = 0; instruction register cleared.
  - alu_en = 0, alu_a = 0, alu_b = 0, alu_cin = 0, alu_op = 0.
  - wb_valid = 0, wb_idx = 0, wb_data = 0.
- FSM states: IDLE, ISSUE, WB.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready, latch op/ra/rb/rd/cin/imm into the instruction register.
  - Non-LDI op → ISSUE. LDI → WB with the result source set to imm.
- ISSUE (one cycle):
  - alu_en = 1.
  - alu_a = rf[ra], alu_b = rf[rb], alu_op = op, alu_cin = cin; all registered outputs, stable for the whole cycle.
  - → WB.
- WB (one cycle):
  - Result = alu_y for ALU ops (ALU output valid on the cycle after en), or imm for LDI.
  - rf[rd] written at the end of the cycle.
  - wb_valid = 1 with wb_idx = rd and wb_data = result.
  - → IDLE.
- alu_en is 0 in every state other than ISSUE. alu_a/b/op/cin hold their last values outside ISSUE.
- Latency: accept at cycle 0 → alu_en at cycle 1 → wb_valid at cycle 2 → instr_ready at cycle 3.
  - ALU-op throughput: 1 instruction per 3 cycles. LDI: 1 per 2 cycles.
- instr_ready is 0 in ISSUE and WB. The upstream source must hold instr_valid and its fields stable until accepted.
- Unsupported ops (0x9–0xE) are issued unchanged. The ALU returns 0 and 0 is written back; no error is raised.
- ra, rb and rd may alias each other, including ra == rb == rd.
  - Operands are read in ISSUE; the write happens in WB, so the old values are used.
- dbg_data reflects a write from the clock edge that ends WB onward.
- Reset asserted during ISSUE or WB aborts the instruction: no writeback, no wb_valid. The stale ALU y is ignored.
- Arithmetic wraps modulo 2^DATA_W inside the ALU; the controller performs no arithmetic.

Optional Feature:
- Macro ALU_ZFLAG_EN.
- Defined:
  - Adds output zf (1 bit), reset to 0.
  - zf updates only at the end of WB to (result == 0), including for LDI; it holds otherwise.
- Undefined: port zf is absent and no flag logic is present.

Decomposition:
- Shared package alu_pkg:
  - DATA_W.
  - Opcode constants: OP_INC 0000, OP_ADD 0001, OP_SUBC 0010, OP_DEC 0011, OP_AND 0100, OP_OR 0101, OP_XOR 0110, OP_NOT 0111, OP_CLR 1000, OP_LDI 1111.
  - FSM state enum.
  - Packed instruction struct (op, ra, rb, rd, cin, imm).
- Sub-module alu_regfile:
  - NREGS × DATA_W.
  - 1 synchronous write port; 3 combinational read ports (a, b, dbg).
  - Async reset to 0.

Test Plan:
- Reset, then LDI r0=5 and LDI r1=3 → wb_valid pulses with (0,5) and (1,3); alu_en never asserted; dbg_data shows 5 and 3.
- ADD rd=2, ra=0, rb=1, cin=1 → alu_en high for exactly 1 cycle with a=5, b=3, op=0001; wb_valid 2 cycles after accept with data 9; rf[2]=9.
- SUBC rd=3, ra=0, rb=1, cin=1 → wb_data = 2 (5 + 12 + 1 mod 16); AND rd=3 → 1; op 1010 → 0 written.
- Hold instr_valid high continuously with back-to-back ADDs → instr_ready pattern 1,0,0,1,0,0; exactly one accept per 3 cycles; no instruction lost or duplicated.
- Assert rst mid-ISSUE of ADD rd=2 with rf[2]=9 → alu_en drops immediately; no wb_valid; rf all 0; instr_ready=1 on the first cycle after rst release.
- With ALU_ZFLAG_EN defined: XOR r0,r0 → zf=1; then LDI 7 → zf=0; zf unchanged while IDLE.
